rr_mux_reg: RTL
===============

# rr_mux_reg

Parametrised N-channel registered data multiplexer with valid/ready handshake on every channel and on the output. It selects one input channel per cycle, either the channel given by a select input (fixed mode) or by a fair round-robin arbiter (round-robin mode), and registers the winner into a single-entry output stage. It generalises the team's combinational 2:1 mux into the channel-aggregation stage that feeds the shared downstream datapath.

## Interface
Parameters:
- NUM_CH, 4, number of input channels (≥2)
- WIDTH, 8, data width per channel
- CH_W, $clog2(NUM_CH), channel index width (derived, not overridden)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- mode_i  in  1  0 = fixed select, 1 = round-robin
- sel_i  in  CH_W  channel index used in fixed mode
- ch_valid_i  in  NUM_CH  per-channel valid
- ch_data_i  in  NUM_CH*WIDTH  channel k data in bits [k*WIDTH +: WIDTH]
- ch_ready_o  out  NUM_CH  one-hot grant/accept; channel k transfers when ch_valid_i[k] & ch_ready_o[k]
- out_valid_o  out  1  output register holds data
- out_data_o  out  WIDTH  registered data
- out_ch_o  out  CH_W  index of channel that supplied out_data_o
- out_ready_i  in  1  downstream accept

## Operation
- load_en = !out_valid_o | out_ready_i. ch_ready_o is all-zero when load_en = 0 or reset is asserted.
- Fixed mode: eligible set = {sel_i} only, and only if sel_i < NUM_CH; otherwise no grant.
- Round-robin mode: eligible = all channels with valid; priority search starts at rr_ptr and wraps NUM_CH-1 → 0.
- Grant: when load_en and an eligible valid channel exists, ch_ready_o = one-hot of the winner; ch_ready_o is combinational from current inputs/state.
- On transfer, next cycle: out_valid_o=1, out_data_o=winner data, out_ch_o=winner index.
- rr_ptr updates only on a transfer in round-robin mode: rr_ptr = (winner+1) mod NUM_CH, wrapping NUM_CH-1 → 0. Fixed-mode transfers leave rr_ptr unchanged.
- Output handshake: out_valid_o & out_ready_i consumes the entry. With no new grant, out_valid_o drops next cycle. With simultaneous consume and grant, the register reloads; full throughput is 1 transfer/cycle.
- While out_valid_o=1 and out_ready_i=0: out_data_o/out_ch_o are held stable, no grants.
- Mode or sel_i changes take effect on the same cycle's arbitration (combinational). rr_ptr is preserved across mode switches.
- Input ch_valid_i may drop without handshake; the block does not rely on valid persistence.

## Timing
- Reset (async assert, sync release with clk): out_valid_o=0, out_data_o=0, out_ch_o=0, rr_ptr=0; ch_ready_o=0 while reset high.
- Latency: input transfer in cycle t → out_valid_o/out_data_o in cycle t+1.
- Reset mid-operation: held output entry is discarded and out_valid_o=0 immediately (asynchronous).
- No combinational path from ch_data_i to any output. Paths out_ready_i→ch_ready_o and ch_valid_i→ch_ready_o are combinational, as permitted.

## Structure
- Package rr_mux_pkg: typedef enum logic {MODE_FIXED=1'b0, MODE_RR=1'b1} mode_e; function for next round-robin pointer.
- Sub-module rr_arbiter (NUM_CH): inputs req, ptr, en; output one-hot gnt and index. The top holds the output register, rr_ptr, and the fixed/RR eligibility mask.

## Test plan
- Reset, then check outputs: reset high mid-stream with out_valid_o=1 → out_valid_o=0, out_data_o=0, rr_ptr=0 without a clock edge.
- Fixed mode, sel_i=2, all valid, data k = 8'h10+k, out_ready_i=1 → ch_ready_o=4'b0100 every cycle; out_data_o=8'h12, out_ch_o=2 one cycle later.
- RR mode, all 4 valid, out_ready_i=1 → grants 0,1,2,3,0 on consecutive cycles; out_ch_o lags by one cycle.
- RR mode, only ch1 and ch3 valid, rr_ptr=2 → grant 3 then 1, alternating; wrap-around from 3 → 0 search confirmed.
- Backpressure: out_ready_i=0 for 3 cycles after a load → ch_ready_o=0, out_data_o stable. Releasing it with a valid input pending → consume and reload in the same cycle, out_valid_o stays 1.
- Fixed mode, sel_i=3 with NUM_CH=3 (index out of range) → ch_ready_o=0 and out_valid_o stays 0. Switching to RR → rr_ptr is still the pre-switch value.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin registered channel mux.
package rr_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Round-robin pointer after a grant to `winner`: the channel just past it, wrapping to 0.
  function automatic int unsigned rr_next(input int unsigned winner, input int unsigned num_ch);
    return (winner + 32'd1 >= num_ch) ? 32'd0 : winner + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: grants the first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int          CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   idx
);

  int  c;
  logic found;

  // Scan NUM_CH positions starting at ptr; the first active request wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      c = (int'(ptr) + i) % int'(NUM_CH);
      if (en && !found && req[c]) begin
        gnt[c] = 1'b1;
        idx    = CH_W'(c);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_reg.sv
// N-channel registered mux: fixed-select or round-robin arbitration into a
// single-entry output register with valid/ready on every side.
module rr_mux_reg
  import rr_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 8,
  parameter int          CH_W   = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode_i,
  input  logic [CH_W-1:0]         sel_i,
  input  logic [NUM_CH-1:0]       ch_valid_i,
  input  logic [NUM_CH*WIDTH-1:0] ch_data_i,
  output logic [NUM_CH-1:0]       ch_ready_o,
  output logic                    out_valid_o,
  output logic [WIDTH-1:0]        out_data_o,
  output logic [CH_W-1:0]         out_ch_o,
  input  logic                    out_ready_i
);

  mode_e             mode;
  logic              load_en;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] gnt;
  logic [CH_W-1:0]   win_idx;
  logic [WIDTH-1:0]  win_data;
  logic              xfer;
  logic [CH_W-1:0]   rr_ptr_q;

  logic              vld_p1;
  logic [WIDTH-1:0]  data_p1;
  logic [CH_W-1:0]   ch_p1;

  // ---- p0: eligibility, arbitration and winner select (combinational) ----
  assign mode    = mode_e'(mode_i);
  assign load_en = !vld_p1 || out_ready_i;

  // Fixed mode narrows the request set to sel_i; an out-of-range sel_i matches nothing.
  always_comb begin
    elig = '0;
    if (mode == MODE_RR) begin
      elig = ch_valid_i;
    end else begin
      for (int k = 0; k < int'(NUM_CH); k++) begin
        if (int'(sel_i) == k) elig[k] = ch_valid_i[k];
      end
    end
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req (elig),
    .ptr (rr_ptr_q),
    .en  (load_en && !reset),
    .gnt (gnt),
    .idx (win_idx)
  );

  assign ch_ready_o = gnt;
  assign xfer       = |gnt;

  // Pick the granted channel's data using the one-hot grant.
  always_comb begin
    win_data = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (gnt[k]) win_data = ch_data_i[k*int'(WIDTH) +: WIDTH];
    end
  end

  // ---- p1: output register and round-robin pointer ----
  // Reload whenever the slot is free or being consumed; advance the pointer only on RR grants.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      ch_p1    <= '0;
      rr_ptr_q <= '0;
    end else begin
      if (load_en) begin
        vld_p1 <= xfer;
        if (xfer) begin
          data_p1 <= win_data;
          ch_p1   <= win_idx;
        end
      end
      if (xfer && mode == MODE_RR) begin
        rr_ptr_q <= CH_W'(rr_next(32'(win_idx), NUM_CH));
      end
    end
  end

  assign out_valid_o = vld_p1;
  assign out_data_o  = data_p1;
  assign out_ch_o    = ch_p1;

endmodule
